// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a small circular FIFO.
// Bit timing comes from a phase accumulator whose carry bit is the baud tick.
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ  = 25000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned ACC_WIDTH = 16,
    parameter int unsigned FIFO_AW   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               txd,
    output logic               tx_busy,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned LW    = FIFO_AW + 1;
    localparam int unsigned AW1   = ACC_WIDTH + 1;
    localparam longint unsigned INC_L =
        ((64'(BAUD) << (ACC_WIDTH - 4)) + 64'(CLK_FREQ >> 5)) / 64'(CLK_FREQ >> 4);
    localparam logic [ACC_WIDTH:0] INC = AW1'(INC_L);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_WIDTH:0]  acc_q, acc_d;
    logic [7:0]          sh_q, sh_d;
    logic [2:0]          bc_q, bc_d;
    logic                txd_q, txd_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;
    logic [LW-1:0]       level_q, level_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [7:0]          mem [DEPTH];
    logic [7:0]          head;
    logic                tick;
    logic                push;
    logic                pop;
    logic                not_empty;

    assign tick      = acc_q[ACC_WIDTH];
    assign head      = mem[rd_ptr_q];
    assign push      = tx_valid && ready_q;
    assign not_empty = (level_q != '0);

    // Next-state and datapath decode for the serialiser
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bc_d    = bc_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (not_empty) begin
                    pop     = 1'b1;
                    sh_d    = head;
                    txd_d   = 1'b0;
                    state_d = START;
                end else begin
                    txd_d = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    txd_d   = sh_q[0];
                    bc_d    = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bc_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        sh_d  = sh_q >> 1;
                        txd_d = sh_q[1];
                        bc_d  = bc_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (not_empty) begin
                        pop     = 1'b1;
                        sh_d    = head;
                        txd_d   = 1'b0;
                        state_d = START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Accumulator is zero whenever the FSM sits in IDLE, so every frame starts in phase
    always_comb begin
        acc_d = '0;
        if (state_d != IDLE) begin
            acc_d = {1'b0, acc_q[ACC_WIDTH-1:0]} + INC;
        end
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        ready_d = (level_d != LW'(DEPTH));
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            sh_q    <= '0;
            bc_q    <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            bc_q    <= bc_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            end
            level_q <= level_d;
            ready_q <= ready_d;
        end
    end

    // Storage needs no reset: pointers and level define what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= tx_data;
        end
    end

    assign txd        = txd_q;
    assign tx_busy    = busy_q;
    assign tx_ready   = ready_q;
    assign fifo_level = level_q;

endmodule
